// File: rtl/ibex_mem_responder.sv
// SRAM-backed, fixed-latency, in-order responder for the core's req/gnt/rvalid bus.
// Grant throttling (gnt_stall_i) and out-of-range errors exercise initiator stall and error paths.
module ibex_mem_responder #(
    parameter int unsigned MemSizeBytes   = 65536,
    parameter logic [31:0] BaseAddr       = 32'h0010_0000,
    parameter int unsigned RespLatency    = 1,
    parameter int unsigned MaxOutstanding = 2
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        req_i,
    output logic        gnt_o,
    output logic        rvalid_o,
    input  logic        we_i,
    input  logic [3:0]  be_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] rdata_o,
    output logic        err_o,
    input  logic        gnt_stall_i
);

    localparam int unsigned MemWords = MemSizeBytes / 4;
    localparam int unsigned IdxW     = (MemWords > 1) ? $clog2(MemWords) : 1;
    localparam logic [32:0] EndAddr  = {1'b0, BaseAddr} + 33'(MemSizeBytes);
    localparam logic [3:0]  MaxOut   = 4'(MaxOutstanding);

    localparam bit ParamsOk =
        (MemSizeBytes >= 4) && ((MemSizeBytes & (MemSizeBytes - 1)) == 0) &&
        ((MemSizeBytes % 4) == 0) && ((BaseAddr & 32'(MemSizeBytes - 1)) == 32'd0) &&
        (RespLatency >= 1) && (RespLatency <= 8) &&
        (MaxOutstanding >= 1) && (MaxOutstanding <= 8);

    logic [31:0]     mem [MemWords];
    logic [3:0]      outstanding;
    logic            in_range;
    logic            handshake;
    logic [IdxW-1:0] idx;
    logic [31:0]     rd_word;
    logic            unused_addr_lsbs;

    logic            new_valid;
    logic [31:0]     new_rdata;
    logic            new_err;

    logic            st_valid [RespLatency];
    logic [31:0]     st_rdata [RespLatency];
    logic            st_err   [RespLatency];

    assign unused_addr_lsbs = ^addr_i[1:0];

    // BaseAddr is aligned to the memory size, so the low address bits are the word index.
    assign in_range  = ({1'b0, addr_i} >= {1'b0, BaseAddr}) && ({1'b0, addr_i} < EndAddr);
    assign idx       = addr_i[IdxW+1:2];
    assign rd_word   = mem[idx];

    assign gnt_o     = req_i & ~gnt_stall_i & (outstanding < MaxOut);
    assign handshake = req_i & gnt_o;

    always_comb begin
        new_valid = 1'b0;
        new_rdata = 32'd0;
        new_err   = 1'b0;
        if (handshake) begin
            new_valid = 1'b1;
            if (!in_range) begin
                new_err = 1'b1;
            end else if (!we_i) begin
                new_rdata = rd_word;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (handshake && we_i && in_range) begin
            for (int k = 0; k < 4; k++) begin
                if (be_i[k]) begin
                    mem[idx][8*k +: 8] <= wdata_i[8*k +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < int'(RespLatency); i++) begin
                st_valid[i] <= 1'b0;
                st_rdata[i] <= 32'd0;
                st_err[i]   <= 1'b0;
            end
        end else begin
            st_valid[0] <= new_valid;
            st_rdata[0] <= new_rdata;
            st_err[0]   <= new_err;
            for (int i = 1; i < int'(RespLatency); i++) begin
                st_valid[i] <= st_valid[i-1];
                st_rdata[i] <= st_rdata[i-1];
                st_err[i]   <= st_err[i-1];
            end
        end
    end

    // Idle stages carry zero data, so the outputs are zero whenever rvalid_o is low.
    assign rvalid_o = st_valid[RespLatency-1];
    assign rdata_o  = st_rdata[RespLatency-1];
    assign err_o    = st_err[RespLatency-1];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            outstanding <= 4'd0;
        end else begin
            case ({handshake, rvalid_o})
                2'b10:   outstanding <= outstanding + 4'd1;
                2'b01:   outstanding <= outstanding - 4'd1;
                default: outstanding <= outstanding;
            endcase
        end
    end

    param_check: assert property (@(posedge clk_i) ParamsOk)
        else $fatal(1, "ibex_mem_responder: parameter outside legal range");

    req_known: assert property (@(posedge clk_i) disable iff (!rst_ni) !$isunknown(req_i))
        else $error("ibex_mem_responder: req_i is unknown");

endmodule

// File: tb/tb_ibex_mem_responder.sv
// Directed bench for ibex_mem_responder: three instances cover default, long-latency
// and single-outstanding configurations.
module tb_ibex_mem_responder;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n  [3];
    logic        req    [3];
    logic        gnt    [3];
    logic        rvalid [3];
    logic        we     [3];
    logic [3:0]  be     [3];
    logic [31:0] addr   [3];
    logic [31:0] wdata  [3];
    logic [31:0] rdata  [3];
    logic        err    [3];
    logic        stall  [3];

    int checks = 0;
    int errors = 0;

    logic [5:0] mo1_gnt_exp = 6'b001001;
    logic [5:0] mo1_rv_exp  = 6'b100100;

    ibex_mem_responder u_dut_def (
        .clk_i(clk), .rst_ni(rst_n[0]), .req_i(req[0]), .gnt_o(gnt[0]), .rvalid_o(rvalid[0]),
        .we_i(we[0]), .be_i(be[0]), .addr_i(addr[0]), .wdata_i(wdata[0]), .rdata_o(rdata[0]),
        .err_o(err[0]), .gnt_stall_i(stall[0])
    );

    ibex_mem_responder #(.RespLatency(3), .MaxOutstanding(4)) u_dut_l3 (
        .clk_i(clk), .rst_ni(rst_n[1]), .req_i(req[1]), .gnt_o(gnt[1]), .rvalid_o(rvalid[1]),
        .we_i(we[1]), .be_i(be[1]), .addr_i(addr[1]), .wdata_i(wdata[1]), .rdata_o(rdata[1]),
        .err_o(err[1]), .gnt_stall_i(stall[1])
    );

    ibex_mem_responder #(.RespLatency(2), .MaxOutstanding(1)) u_dut_mo1 (
        .clk_i(clk), .rst_ni(rst_n[2]), .req_i(req[2]), .gnt_o(gnt[2]), .rvalid_o(rvalid[2]),
        .we_i(we[2]), .be_i(be[2]), .addr_i(addr[2]), .wdata_i(wdata[2]), .rdata_o(rdata[2]),
        .err_o(err[2]), .gnt_stall_i(stall[2])
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Called just after a rising edge; returns just after a rising edge.
    task automatic access(input int i, input string tag, input logic w, input logic [3:0] b,
                          input logic [31:0] a, input logic [31:0] d, input int exp_lat,
                          input logic [31:0] exp_rdata, input logic exp_err);
        int          n;
        int          lat;
        logic [31:0] rd;
        logic        e;
        req[i] = 1'b1; we[i] = w; be[i] = b; addr[i] = a; wdata[i] = d;
        n = 0;
        @(negedge clk);
        while (!gnt[i] && n < 20) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_gnt"}, 32'(gnt[i]), 32'd1);
        @(posedge clk); #1;
        req[i] = 1'b0; we[i] = 1'b0;
        lat = 0; rd = 32'd0; e = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (rvalid[i]) begin
                lat = k; rd = rdata[i]; e = err[i];
                break;
            end
        end
        check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        check({tag, "_rdata"}, rd, exp_rdata);
        check({tag, "_err"}, 32'(e), 32'(exp_err));
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int nresp;
        int g_cnt;
        int r_cnt;
        int rv_seen;

        for (int i = 0; i < 3; i++) begin
            rst_n[i] = 1'b0; req[i] = 1'b0; we[i] = 1'b0; be[i] = 4'h0;
            addr[i] = 32'd0; wdata[i] = 32'd0; stall[i] = 1'b0;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            check("rst_gnt", 32'(gnt[i]), 32'd0);
            check("rst_rvalid", 32'(rvalid[i]), 32'd0);
            check("rst_rdata", rdata[i], 32'd0);
            check("rst_err", 32'(err[i]), 32'd0);
        end
        for (int i = 0; i < 3; i++) rst_n[i] = 1'b1;
        @(posedge clk); #1;

        // Full and partial writes, default configuration
        access(0, "wr_full", 1'b1, 4'hF, 32'h0010_0010, 32'hDEAD_BEEF, 1, 32'd0, 1'b0);
        access(0, "rd_full", 1'b0, 4'h0, 32'h0010_0010, 32'd0, 1, 32'hDEAD_BEEF, 1'b0);
        access(0, "wr_part", 1'b1, 4'b0101, 32'h0010_0010, 32'h1122_3344, 1, 32'd0, 1'b0);
        access(0, "rd_part", 1'b0, 4'h0, 32'h0010_0010, 32'd0, 1, 32'hDE22_BE44, 1'b0);
        access(0, "rd_lsbs", 1'b0, 4'h0, 32'h0010_0013, 32'd0, 1, 32'hDE22_BE44, 1'b0);

        // Range boundaries
        access(0, "wr_base", 1'b1, 4'hF, 32'h0010_0000, 32'h1234_5678, 1, 32'd0, 1'b0);
        access(0, "wr_oor", 1'b1, 4'hF, 32'h0011_0000, 32'hCAFE_F00D, 1, 32'd0, 1'b1);
        access(0, "rd_oor", 1'b0, 4'hF, 32'h0011_0000, 32'd0, 1, 32'd0, 1'b1);
        access(0, "rd_base", 1'b0, 4'h0, 32'h0010_0000, 32'd0, 1, 32'h1234_5678, 1'b0);
        access(0, "wr_last", 1'b1, 4'hF, 32'h0010_FFFC, 32'hA5A5_5A5A, 1, 32'd0, 1'b0);
        access(0, "rd_last", 1'b0, 4'h0, 32'h0010_FFFC, 32'd0, 1, 32'hA5A5_5A5A, 1'b0);
        access(0, "rd_below", 1'b0, 4'h0, 32'h000F_FFFC, 32'd0, 1, 32'd0, 1'b1);

        // Grant stall
        stall[0] = 1'b1; req[0] = 1'b1; we[0] = 1'b0; addr[0] = 32'h0010_0010;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check("stall_gnt", 32'(gnt[0]), 32'd0);
            @(posedge clk); #1;
        end
        stall[0] = 1'b0;
        @(negedge clk);
        check("stall_release_gnt", 32'(gnt[0]), 32'd1);
        @(posedge clk); #1;
        req[0] = 1'b0;
        @(negedge clk);
        check("stall_rvalid", 32'(rvalid[0]), 32'd1);
        check("stall_rdata", rdata[0], 32'hDE22_BE44);
        @(posedge clk); #1;

        // Back-to-back reads, latency 3, four outstanding
        for (int k = 0; k < 4; k++)
            access(1, "l3_wr", 1'b1, 4'hF, 32'h0010_0000 + 32'(4 * k),
                   32'hA000_0000 + 32'(k) * 32'h111, 3, 32'd0, 1'b0);
        nresp = 0;
        for (int c = 0; c < 14; c++) begin
            if (c < 6) begin
                req[1] = 1'b1; we[1] = 1'b0; addr[1] = 32'h0010_0000 + 32'(4 * (c % 4));
            end else begin
                req[1] = 1'b0;
            end
            @(negedge clk);
            if (c < 6) check("b2b_gnt", 32'(gnt[1]), 32'd1);
            if (rvalid[1]) begin
                check("b2b_cycle", 32'(c), 32'(3 + nresp));
                check("b2b_data", rdata[1], 32'hA000_0000 + 32'(nresp % 4) * 32'h111);
                nresp++;
            end
            @(posedge clk); #1;
        end
        check("b2b_count", 32'(nresp), 32'd6);

        // Single outstanding, latency 2, request held
        req[2] = 1'b1; we[2] = 1'b0; addr[2] = 32'h0010_0000;
        g_cnt = 0; r_cnt = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            check("mo1_gnt", 32'(gnt[2]), 32'(mo1_gnt_exp[c]));
            check("mo1_rvalid", 32'(rvalid[2]), 32'(mo1_rv_exp[c]));
            if (gnt[2]) g_cnt++;
            if (rvalid[2]) r_cnt++;
            check("mo1_outstanding_le1", 32'((g_cnt - r_cnt) > 1), 32'd0);
            @(posedge clk); #1;
        end
        req[2] = 1'b0;
        repeat (4) @(posedge clk);
        #1;

        // Reset one cycle after a read grant
        access(1, "rst_wr", 1'b1, 4'hF, 32'h0010_0040, 32'h0BAD_F00D, 3, 32'd0, 1'b0);
        req[1] = 1'b1; we[1] = 1'b0; addr[1] = 32'h0010_0040;
        @(negedge clk);
        check("rst_rd_gnt", 32'(gnt[1]), 32'd1);
        @(posedge clk); #1;
        req[1] = 1'b0;
        @(negedge clk);
        rst_n[1] = 1'b0;
        repeat (2) @(negedge clk);
        rst_n[1] = 1'b1;
        rv_seen = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (rvalid[1]) rv_seen++;
        end
        check("rst_no_rvalid", 32'(rv_seen), 32'd0);
        @(posedge clk); #1;
        access(1, "rst_rd_keep", 1'b0, 4'h0, 32'h0010_0040, 32'd0, 3, 32'h0BAD_F00D, 1'b0);
        access(1, "rst_rd_old", 1'b0, 4'h0, 32'h0010_0004, 32'd0, 3, 32'hA000_0111, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
